four_bit_seq_divider: RTL

FOUR_BIT_SEQ_DIVIDER -- requirements
Module: four_bit_seq_divider

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_sub_stage.sv | 26 ++
 rtl/four_bit_seq_divider.sv | 131 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and the step-counter width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W = 4;

    // Counter must hold W-1; a one-bit counter is the floor for tiny widths
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_W);

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract the divisor at W+1 bits, keep or restore the partial remainder.
module div_sub_stage
    import div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // Quotient bit is 1 when the shifted remainder covers the divisor
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? trial[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/four_bit_seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Optional macro FOUR_BIT_SEQ_DIVIDER_SIGNED_EN adds a signed_mode input
// for two's-complement division; latency is the same in both builds.
module four_bit_seq_divider
    import div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
    input  logic         signed_mode,
`endif
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = cnt_width(W);

    state_t        state, next_state;
    logic [W-1:0]  dividend, divisor, a_orig, part_rem, q_acc;
    logic [CW-1:0] step_cnt;
    logic          neg_q, neg_r;
    logic [W-1:0]  stage_rem;
    logic          stage_q;
    logic [W-1:0]  a_mag, b_mag;
    logic          a_neg, b_neg;
    logic [W-1:0]  q_raw, q_final, r_final;
    logic          accept, last_step;

    div_sub_stage #(.W(W)) u_stage (
        .rem_in  (part_rem),
        .bit_in  (dividend[W-1]),
        .divisor (divisor),
        .rem_out (stage_rem),
        .q_bit   (stage_q)
    );

    // Operand conditioning: magnitudes and sign flags captured at start
    always_comb begin
`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
        a_neg = signed_mode & A[W-1];
        b_neg = signed_mode & B[W-1];
`else
        a_neg = 1'b0;
        b_neg = 1'b0;
`endif
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
    end

    // Final result: divide-by-zero bypasses sign fixing and returns raw A
    always_comb begin
        q_raw   = {q_acc[W-2:0], stage_q};
        q_final = neg_q ? -q_raw : q_raw;
        r_final = neg_r ? -stage_rem : stage_rem;
        if (divisor == '0) begin
            q_final = '1;
            r_final = a_orig;
        end
    end

    // Next-state logic; DONE always returns to IDLE, start ignored elsewhere
    always_comb begin
        next_state = state;
        accept     = (state == IDLE) && start;
        last_step  = (state == CALC) && (step_cnt == '0);
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (step_cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Datapath and registered outputs; results only change at the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend  <= '0;
            divisor   <= '0;
            a_orig    <= '0;
            part_rem  <= '0;
            q_acc     <= '0;
            step_cnt  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            busy <= (next_state == CALC);
            done <= (next_state == DONE);
            if (accept) begin
                dividend <= a_mag;
                divisor  <= b_mag;
                a_orig   <= A;
                part_rem <= '0;
                q_acc    <= '0;
                step_cnt <= CW'(W - 1);
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= 1'b0;
            end else if (state == CALC) begin
                dividend <= dividend << 1;
                part_rem <= stage_rem;
                q_acc    <= q_raw;
                step_cnt <= step_cnt - CW'(1);
                if (last_step) begin
                    quotient  <= q_final;
                    remainder <= r_final;
                    div_zero  <= (divisor == '0);
                end
            end
        end
    end

endmodule
